uart_rx: RTL and testbench
==========================

# uart_rx

Asynchronous serial receiver for 8N1 frames, LSB first, idle-high line. It is the receive end of the UART link whose transmit side is timed by the baud divider. It oversamples the raw `rx` pin on the system clock, resynchronises it, and samples each bit at mid-bit. Each received byte is presented with a one-cycle valid strobe; frames with a bad stop bit are flagged.

## Interface
- `CLKS_PER_BIT`, default 1302: system clocks per bit period. Must be even and ≥ 8. 1302 is one full period of the existing divided baud clock.
- `CNT_W`, default 11: counter width. Must satisfy 2^CNT_W > CLKS_PER_BIT.
- `clk` input 1: system clock. All logic is on the posedge.
- `rst_n` input 1: asynchronous active-low reset.
- `rx` input 1: raw serial line, asynchronous to `clk`.
- `data_out` output 8: last good received byte. Held until the next good frame.
- `data_valid` output 1: one-cycle pulse when `data_out` is updated.
- `frame_err` output 1: one-cycle pulse when the stop bit is sampled as 0.
- `busy` output 1: high in every state except IDLE.

## Operation
- **Synchroniser**
  - Two-flop chain `rx` → `rx_s`. Both flops reset to 1.
  - All decisions use `rx_s` only.
- **State machine**
  - States: IDLE, START, DATA, STOP, BREAK.
  - Bit counter `cnt` is `CNT_W` bits wide. Bit index `idx` is 3 bits. Shift register `sh` is 8 bits.
- **IDLE**
  - `cnt`=0, `idx`=0.
  - On `rx_s`==0, go to START.
- **START**
  - `cnt` increments each cycle.
  - At `cnt`==CLKS_PER_BIT/2−1:
    - if `rx_s`==0, go to DATA with `cnt`=0;
    - if `rx_s`==1, treat as a glitch: go to IDLE. No output pulse.
- **DATA**
  - At `cnt`==CLKS_PER_BIT−1: `sh` <= {`rx_s`, `sh[7:1]`}, `cnt`=0, `idx`++.
  - When the sample taken has `idx`==7, go to STOP.
- **STOP**
  - At `cnt`==CLKS_PER_BIT−1:
    - if `rx_s`==1: `data_out`<=`sh`, pulse `data_valid`, go to IDLE;
    - else: pulse `frame_err`, leave `data_out` unchanged, go to BREAK.
- **BREAK**
  - Wait for `rx_s`==1, then go to IDLE.
  - This prevents a held-low line from being re-decoded as a stream of frames.
- **Exclusivity**
  - `data_valid` and `frame_err` are never high in the same cycle.
  - Neither is ever high for two consecutive cycles.
- **Back-to-back frames**
  - IDLE is re-entered in the cycle after the stop sample.
  - A start edge that is already present is detected on the next posedge. No idle gap is required.
- **Reset**
  - Reset values: state=IDLE, `cnt`=0, `idx`=0, `sh`=0, `data_out`=8'h00, `data_valid`=0, `frame_err`=0, `busy`=0, sync flops=1.
  - Reset mid-frame aborts the frame silently. No pulse is produced.
  - After release, a line that is still low is treated as a new start bit.

## Timing
- t0 is the first posedge at which the first sync flop captures `rx`=0.
- `rx_s` is low after posedge t0+1. The IDLE→START transition occurs at posedge t0+2, and `busy` rises then.
- The start bit is validated at t0+2+CLKS_PER_BIT/2.
- Data bit k (k=0..7) is sampled at t0+2+CLKS_PER_BIT/2+(k+1)·CLKS_PER_BIT.
- The stop bit is sampled at t0+2+CLKS_PER_BIT/2+9·CLKS_PER_BIT.
  - `data_valid` or `frame_err` is high for the cycle following that edge.
  - `busy` falls on the same edge.
- Benches may allow ±1 cycle on these instants.
- Sampling lands at mid-bit, giving ±(CLKS_PER_BIT/2−3) cycles of tolerance to baud mismatch over the frame.
- A start glitch shorter than CLKS_PER_BIT/2−2 cycles is rejected.
- Combinational paths from input to output: none. All outputs are registered.

## Test plan
All scenarios use CLKS_PER_BIT=16.
1. **Reset defaults:** hold `rx`=1, assert `rst_n`=0 → `data_out`=8'h00 and `data_valid`=`frame_err`=`busy`=0. After release, 50 idle cycles give no pulses.
2. **Single byte:** send 8'hA5 at 16 clk/bit → exactly one `data_valid` pulse, `data_out`=8'hA5, at t0+2+8+144 (±1). `frame_err` never asserts.
3. **Back-to-back:** send 8'h00, 8'hFF, 8'h3C with no idle gap → three `data_valid` pulses with those values, spaced 160 cycles (±1).
4. **Glitch rejection:** drive `rx` low for 4 cycles, then high → START aborts to IDLE, `busy` drops, no `data_valid` or `frame_err`.
5. **Framing error and break:** send 8'h55 with stop bit 0, then hold low for 64 cycles → one `frame_err` pulse, `data_out` keeps its prior value, and the state stays BREAK until high. A following good 8'h81 is then received correctly.
6. **Reset mid-frame:** pulse `rst_n` low during data bit 3 → no pulse, state is IDLE. The next full frame 8'h5A is received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 8N1 asynchronous serial receiver, LSB first, idle-high line.
// The raw rx pin is resynchronised through two flops and every bit is
// sampled at mid-bit by counting system clocks. A good frame updates
// data_out with a one-cycle data_valid pulse. A frame whose stop bit reads
// low gives a one-cycle frame_err pulse and then waits for the line to go
// high again, so a held-low line is not decoded as a stream of frames.

module uart_rx #(
    parameter int CLKS_PER_BIT = 1302,
    parameter int CNT_W        = 11
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       frame_err,
    output logic       busy
);

    // Elaboration-time guard on the counter sizing and bit-period rules.
    if ((CLKS_PER_BIT < 8) || ((CLKS_PER_BIT % 2) != 0) ||
        ((64'd1 << CNT_W) <= 64'(CLKS_PER_BIT))) begin : g_bad_param
        $error("uart_rx: CLKS_PER_BIT must be even, >= 8 and < 2**CNT_W");
    end

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    // Count values at which the start bit (half period) and the data and
    // stop bits (full period) are sampled.
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic             rx_meta;
    logic             rx_s;
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       idx;
    logic [7:0]       sh;

    // Two-flop synchroniser; both flops reset to the idle (high) line level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make rx_s take the previous
            // rx_meta, giving a real two-stage chain rather than one flop.
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // Receive FSM: bit timing, shifting, and the registered output strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            idx        <= '0;
            sh         <= '0;
            data_out   <= 8'h00;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            // Strobes default low so each can only ever be a single cycle.
            data_valid <= 1'b0;
            frame_err  <= 1'b0;

            case (state)
                IDLE: begin
                    cnt <= '0;
                    idx <= '0;
                    if (!rx_s) begin
                        state <= START;
                        busy  <= 1'b1;
                    end
                end

                START: begin
                    if (cnt == HALF_LAST) begin
                        cnt <= '0;
                        if (!rx_s) begin
                            state <= DATA;
                        end else begin
                            // Line went back high before mid start bit: glitch.
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

                DATA: begin
                    if (cnt == FULL_LAST) begin
                        cnt <= '0;
                        sh  <= {rx_s, sh[7:1]};
                        idx <= idx + 3'd1;
                        if (idx == 3'd7) begin
                            state <= STOP;
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

                STOP: begin
                    if (cnt == FULL_LAST) begin
                        cnt <= '0;
                        if (rx_s) begin
                            data_out   <= sh;
                            data_valid <= 1'b1;
                            state      <= IDLE;
                            busy       <= 1'b0;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= BREAK;
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

                BREAK: begin
                    cnt <= '0;
                    if (rx_s) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: drives 8N1 frames into uart_rx at 16 clocks per bit and
// compares every data_valid / frame_err pulse (time, kind, data_out)
// against expectations from a vector table and a last-good-byte model.

module tb_uart_rx;

    localparam int C         = 16;
    localparam int CW        = 5;
    localparam int FRAME_LAT = 2 + C / 2 + 9 * C;  // t0 to stop-sample edge

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_err;
    logic       busy;

    uart_rx #(
        .CLKS_PER_BIT(C),
        .CNT_W       (CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .data_out  (data_out),
        .data_valid(data_valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // One pulse event: cycle number, 1 = data_valid / 0 = frame_err, data_out.
    typedef struct {
        int         t;
        logic       valid;
        logic [7:0] data;
    } ev_t;

    // Table record: frame inputs plus the expected pulse kind and data_out.
    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         gap;
        logic       exp_valid;
        logic [7:0] exp_data_out;
    } vec_t;

    int   cyc = 0;
    ev_t  obs_q[$];
    int   obs_rd = 0;
    int   viol = 0;
    logic prev_pulse = 1'b0;

    ev_t        exp_q[$];
    vec_t       vecs[6];
    logic [7:0] last_good;
    int         checks = 0;
    int         errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor: logs every strobe and counts exclusivity violations.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (data_valid || frame_err) begin
                obs_q.push_back('{cyc, data_valid, data_out});
            end
            if ((data_valid && frame_err) || (prev_pulse && (data_valid || frame_err))) begin
                viol <= viol + 1;
            end
            prev_pulse <= data_valid | frame_err;
        end else begin
            prev_pulse <= 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic check_near(input string name, input int got, input int exp);
        checks++;
        if ((got < exp - 1) || (got > exp + 1)) begin
            errors++;
            $display("FAIL %s: got cycle %0d expected %0d (+/-1)", name, got, exp);
        end
    endtask

    // Send one frame starting at a negedge; leaves rx at the stop level,
    // then idles high for gap cycles. Also checks busy rise and fall timing.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int gap,
                              input logic exp_valid, input logic [7:0] exp_data);
        int         t0;
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        t0   = cyc + 1;
        exp_q.push_back('{t0 + FRAME_LAT, exp_valid, exp_data});
        for (int i = 0; i < 10; i++) begin
            rx = bits[i];
            for (int j = 1; j <= C; j++) begin
                @(negedge clk);
                if (i == 0 && j == 2) check("busy_before_start", busy, 0);
                if (i == 0 && j == 3) check("busy_rise", busy, 1);
                if (i == 9 && j == 10) check("busy_before_stop", busy, 1);
                if (i == 9 && j == 11) check("busy_after_stop", busy, {31'b0, ~stop});
            end
        end
        if (gap > 0) begin
            rx = 1'b1;
            repeat (gap) @(negedge clk);
        end
    endtask

    // Match logged pulses against expected ones, in order, then clear both.
    task automatic compare_events(input string tag);
        int  n_obs;
        ev_t o;
        ev_t e;
        n_obs = obs_q.size() - obs_rd;
        check({tag, "_pulse_count"}, n_obs, exp_q.size());
        for (int i = 0; i < exp_q.size() && i < n_obs; i++) begin
            o = obs_q[obs_rd + i];
            e = exp_q[i];
            check_near({tag, "_pulse_time"}, o.t, e.t);
            check({tag, "_pulse_kind"}, o.valid, e.valid);
            check({tag, "_data_out"}, o.data, e.data);
        end
        obs_rd = obs_q.size();
        exp_q.delete();
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rb;
        logic       rs;
        int         rg;

        vecs[0] = '{8'hA5, 1'b1, 20, 1'b1, 8'hA5};
        vecs[1] = '{8'h00, 1'b1, 0,  1'b1, 8'h00};
        vecs[2] = '{8'hFF, 1'b1, 0,  1'b1, 8'hFF};
        vecs[3] = '{8'h3C, 1'b1, 30, 1'b1, 8'h3C};
        vecs[4] = '{8'hC3, 1'b0, 5,  1'b0, 8'h3C};
        vecs[5] = '{8'h81, 1'b1, 10, 1'b1, 8'h81};

        // Reset defaults.
        rst_n     = 1'b0;
        rx        = 1'b1;
        last_good = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_data_out", data_out, 8'h00);
        check("reset_data_valid", data_valid, 0);
        check("reset_frame_err", frame_err, 0);
        check("reset_busy", busy, 0);
        rst_n = 1'b1;
        repeat (50) @(negedge clk);
        check("idle_busy", busy, 0);
        compare_events("idle");

        // Table: single byte, back-to-back bytes, bad stop, recovery.
        for (int i = 0; i < 6; i++) begin
            send_frame(vecs[i].data, vecs[i].stop, vecs[i].gap,
                       vecs[i].exp_valid, vecs[i].exp_data_out);
        end
        compare_events("table");
        last_good = 8'h81;

        // Start glitch of 4 cycles must be rejected.
        rx = 1'b0;
        repeat (3) @(negedge clk);
        check("glitch_busy_start", busy, 1);
        @(negedge clk);
        rx = 1'b1;
        repeat (12) @(negedge clk);
        check("glitch_busy_end", busy, 0);
        compare_events("glitch");

        // Framing error followed by a held-low break, then a good frame.
        send_frame(8'h55, 1'b0, 0, 1'b0, last_good);
        repeat (64) @(negedge clk);
        check("break_busy", busy, 1);
        check("break_data_out", data_out, last_good);
        rx = 1'b1;
        repeat (4) @(negedge clk);
        check("break_exit_busy", busy, 0);
        send_frame(8'h81, 1'b1, 5, 1'b1, 8'h81);
        compare_events("break");

        // Reset asserted during data bit 3 of 8'h08.
        rx = 1'b0;
        repeat (4 * C) @(negedge clk);
        rx = 1'b1;
        repeat (C / 2) @(negedge clk);
        check("midframe_busy", busy, 1);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("midframe_reset_busy", busy, 0);
        check("midframe_reset_data_out", data_out, 8'h00);
        rst_n = 1'b1;
        repeat (2 * C) @(negedge clk);
        check("midframe_idle_busy", busy, 0);
        compare_events("reset_mid");
        send_frame(8'h5A, 1'b1, 5, 1'b1, 8'h5A);
        compare_events("after_reset");
        last_good = 8'h5A;

        // Random frames against the last-good-byte model.
        for (int n = 0; n < 16; n++) begin
            rb = 8'($urandom);
            rs = ($urandom_range(0, 3) != 0);
            rg = int'($urandom_range(0, 24));
            if (!rs && rg < 3) rg = 3;
            if (rs) last_good = rb;
            send_frame(rb, rs, rg, rs, last_good);
        end
        compare_events("random");

        check("pulse_exclusivity", viol, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
